// File: rtl/ram_burst_reader.sv
// ram_burst_reader: burst read master for the RAM read port.
// Credit-limited issue into a 3-entry stream buffer.
module ram_burst_reader #(
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int DWIDTH = 8,
  parameter int LWIDTH = AWIDTH + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [LWIDTH-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              renable,
  output logic [AWIDTH-1:0] raddr,
  input  logic [DWIDTH-1:0] rdata,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] raddr_q, raddr_d;
  logic [LWIDTH-1:0] rem_q, rem_d;
  logic              ren_q, ren_d;
  logic              rlast_q, rlast_d;
  logic              inf_q, ilast_q;
  logic              done_q, done_d;

  logic [DWIDTH-1:0] bdat_q [0:2];
  logic              blast_q [0:2];
  logic [1:0]        wp_q, rp_q, occ_q;
  logic [1:0]        occ_n;
  logic              push, pop;

  function automatic logic [AWIDTH-1:0] inc(
    input logic [AWIDTH-1:0] a
  );
    if (a == AWIDTH'(DEPTH - 1)) return '0;
    return a + 1'b1;
  endfunction

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign renable = ren_q;
  assign raddr   = raddr_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = bdat_q[rp_q];
  assign m_last  = m_valid & blast_q[rp_q];

  assign push  = inf_q;
  assign pop   = m_valid & m_ready;
  assign occ_n = occ_q + 2'(push) - 2'(pop);

  // Next-state: issue decision for next cycle uses post-edge occupancy
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    ren_d   = 1'b0;
    rlast_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            ren_d   = 1'b1;
            raddr_d = base_addr;
            addr_d  = inc(base_addr);
            rem_d   = length - 1'b1;
            rlast_d = (length == LWIDTH'(1));
            state_d = (length == LWIDTH'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if ({1'b0, occ_n} + {2'b0, ren_q} < 3'd3) begin
          ren_d   = 1'b1;
          raddr_d = addr_q;
          addr_d  = inc(addr_q);
          rem_d   = rem_q - 1'b1;
          rlast_d = (rem_q == LWIDTH'(1));
          if (rem_q == LWIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers and read pipeline tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      raddr_q <= '0;
      rem_q   <= '0;
      ren_q   <= 1'b0;
      rlast_q <= 1'b0;
      inf_q   <= 1'b0;
      ilast_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      ren_q   <= ren_d;
      rlast_q <= rlast_d;
      inf_q   <= ren_q;
      ilast_q <= rlast_q;
      done_q  <= done_d;
    end
  end

  // Output buffer: push returning read data, pop on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        bdat_q[i]  <= '0;
        blast_q[i] <= 1'b0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      occ_q <= occ_n;
      if (push) begin
        bdat_q[wp_q]  <= rdata;
        blast_q[wp_q] <= ilast_q;
        wp_q <= (wp_q == 2'd2) ? 2'd0 : wp_q + 2'd1;
      end
      if (pop) begin
        rp_q <= (rp_q == 2'd2) ? 2'd0 : rp_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: bench with RAM model, stream
// scoreboard and directed burst scenarios.
module tb_ram_burst_reader;

  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, renable;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;

  int total = 0;
  int bad = 0;

  ram_burst_reader #(
    .DEPTH(DEPTH), .AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .renable(renable),
    .raddr(raddr), .rdata(rdata), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (renable) rdata <= {3'b0, raddr} ^ 8'hA5;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event", nm);
  endtask

  int          cyc_n = 0;
  int          exp_addr[$];
  logic [7:0]  exp_dat[$];
  bit          busy_m = 0, done_m = 0;
  int          issued = 0, popped = 0;
  int          iss1 = 0, iss2 = 0;
  int          ren_cyc[$];
  int          raddr_log[$];
  int          val_first = -1;
  logic [7:0]  got[$];
  logic [7:0]  last_word = '0;

  always @(negedge clk) begin : model
    bit bn, dn;
    cyc_n++;
    if (!rst_n) begin
      exp_addr.delete();
      exp_dat.delete();
      busy_m = 0; done_m = 0;
      issued = 0; popped = 0; iss1 = 0; iss2 = 0;
    end else begin
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      chk("m_valid", m_valid, iss2 > popped);
      bn = busy_m;
      dn = 0;
      if (renable) begin
        ren_cyc.push_back(cyc_n);
        raddr_log.push_back(int'(raddr));
        issued++;
        if (exp_addr.size() == 0) fail("spurious_renable");
        else chk("raddr", raddr, exp_addr.pop_front());
      end
      chk("credit", (issued - popped) <= 3, 1);
      if (m_valid) begin
        if (val_first < 0) val_first = cyc_n;
        if (exp_dat.size() == 0) fail("spurious_valid");
        else begin
          chk("m_data", m_data, exp_dat[0]);
          chk("m_last", m_last, exp_dat.size() == 1);
          if (m_ready) begin
            got.push_back(m_data);
            popped++;
            if (exp_dat.size() == 1) begin
              last_word = m_data;
              bn = 0;
              dn = 1;
            end
            void'(exp_dat.pop_front());
          end
        end
      end
      if (start && !busy_m) begin
        if (length == 0) dn = 1;
        else begin
          for (int i = 0; i < int'(length); i++) begin
            exp_addr.push_back((int'(base_addr) + i) % DEPTH);
            exp_dat.push_back(8'(((int'(base_addr) + i) % DEPTH) ^ 8'hA5));
          end
          bn = 1;
        end
      end
      busy_m = bn;
      done_m = dn;
      iss2 = iss1;
      iss1 = issued;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input int b, input int l);
    base_addr = AW'(b);
    length = LW'(l);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      cyc(1);
      n++;
    end
    if (n >= 300) fail("done_timeout");
  endtask

  task automatic clear_logs();
    ren_cyc.delete();
    raddr_log.delete();
    got.delete();
    val_first = -1;
  endtask

  logic [7:0] e1 [0:7];
  logic [7:0] e2 [0:3];
  int         a2 [0:3];

  initial begin
    e1 = '{8'hA1, 8'hA0, 8'hA3, 8'hA2, 8'hAD, 8'hAC, 8'hAF, 8'hAE};
    e2 = '{8'hBB, 8'hBA, 8'hA5, 8'hA4};
    a2 = '{30, 31, 0, 1};
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_ren", renable, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    rst_n = 1'b1;
    cyc(2);

    clear_logs();
    m_ready = 1'b1;
    go(4, 8);
    wait_done();
    cyc(2);
    chk("t1_nren", ren_cyc.size(), 8);
    if (ren_cyc.size() == 8) begin
      chk("t1_consec", ren_cyc[7] - ren_cyc[0], 7);
      chk("t1_lat", val_first - ren_cyc[0], 2);
      chk("t1_a0", raddr_log[0], 4);
      chk("t1_a7", raddr_log[7], 11);
    end
    chk("t1_ngot", got.size(), 8);
    if (got.size() == 8)
      for (int i = 0; i < 8; i++) chk("t1_data", got[i], e1[i]);
    chk("t1_last", last_word, 8'hAE);

    clear_logs();
    go(30, 4);
    wait_done();
    cyc(2);
    chk("t2_ngot", got.size(), 4);
    if (got.size() == 4 && raddr_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t2_data", got[i], e2[i]);
        chk("t2_addr", raddr_log[i], a2[i]);
      end
    chk("t2_last", last_word, 8'hA4);

    clear_logs();
    m_ready = 1'b0;
    go(0, 10);
    cyc(7);
    chk("t3_stall_ren", ren_cyc.size(), 3);
    chk("t3_valid", m_valid, 1);
    chk("t3_hold", m_data, 8'hA5);
    m_ready = 1'b1;
    wait_done();
    cyc(2);
    chk("t3_ngot", got.size(), 10);
    if (got.size() == 10)
      for (int i = 0; i < 10; i++) chk("t3_data", got[i], 8'(i ^ 8'hA5));

    clear_logs();
    go(0, 0);
    chk("t4_zl_done", done, 1);
    chk("t4_zl_busy", busy, 0);
    cyc(3);
    chk("t4_zl_ren", ren_cyc.size(), 0);
    go(2, 6);
    cyc(2);
    go(16, 3);
    wait_done();
    cyc(2);
    chk("t4_ngot", got.size(), 6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk("t4_data", got[i], 8'((i + 2) ^ 8'hA5));
    chk("t4_nren", raddr_log.size(), 6);

    clear_logs();
    go(0, 8);
    begin
      int n = 0;
      while (popped < 3 && n < 100) begin
        cyc(1);
        n++;
      end
      if (n >= 100) fail("t5_timeout");
    end
    rst_n = 1'b0;
    #1;
    chk("t5_ren", renable, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_valid", m_valid, 0);
    chk("t5_last", m_last, 0);
    chk("t5_raddr", raddr, 0);
    chk("t5_mdata", m_data, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    clear_logs();
    go(8, 2);
    wait_done();
    cyc(2);
    chk("t5_ngot", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_d0", got[0], 8'hAD);
      chk("t5_d1", got[1], 8'hAC);
    end
    chk("t5_lastw", last_word, 8'hAC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
